// File: rtl/game_phase_ctrl_pkg.sv
// Shared definitions for the game phase sequencer and the renderers that
// select their screen from the one-hot phase vector.
package game_pkg;

   localparam int PHASE_W = 7;

   // Bit positions inside the one-hot phase vector.
   localparam int IDX_TITLE     = 6;
   localparam int IDX_PLAYING   = 5;
   localparam int IDX_PAUSED    = 4;
   localparam int IDX_DYING     = 3;
   localparam int IDX_CLEAR     = 2;
   localparam int IDX_GAME_OVER = 1;
   localparam int IDX_WIN       = 0;

   typedef enum logic [PHASE_W-1:0] {
      PH_TITLE     = 7'b1000000,
      PH_PLAYING   = 7'b0100000,
      PH_PAUSED    = 7'b0010000,
      PH_DYING     = 7'b0001000,
      PH_CLEAR     = 7'b0000100,
      PH_GAME_OVER = 7'b0000010,
      PH_WIN       = 7'b0000001
   } phase_e;

   // Width that holds a count of up to max(a, b) frames, never below 1 bit.
   function automatic int timer_width(input int a, input int b);
      int biggest;
      biggest = (a > b) ? a : b;
      return (biggest > 1) ? $clog2(biggest) : 1;
   endfunction

endpackage

// File: rtl/game_phase_ctrl_if.sv
// Bundle of key/game-logic inputs and screen/counter outputs of the sequencer.
interface game_phase_ctrl_if;
   import game_pkg::*;

   logic               frame_tick;
   logic               start;
   logic               pause;
   logic               mario_alive;
   logic               level_end;
   logic [PHASE_W-1:0] phase;
   logic [3:0]         lives_left;
   logic [3:0]         level;
   logic               load_level;
   logic               respawn;

   modport master (
      output frame_tick, start, pause, mario_alive, level_end,
      input  phase, lives_left, level, load_level, respawn
   );

   modport slave (
      input  frame_tick, start, pause, mario_alive, level_end,
      output phase, lives_left, level, load_level, respawn
   );
endinterface

// File: rtl/game_phase_ctrl_countdown.sv
// Reusable frame countdown: load N-1, expire on the tick that arrives at 0,
// so a timed screen lasts exactly N frame ticks.
module frame_countdown #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             tick,
   output logic             expired
);

   logic [WIDTH-1:0] count;

   // Load wins over a coincident tick; the count rests at zero after expiry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (tick && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign expired = tick && (count == '0);

endmodule

// File: rtl/game_phase_ctrl.sv
// Game phase sequencer: title/play/pause/death/clear/game-over/win screens,
// lives and level counters, paced by the per-frame tick.
module game_phase_ctrl
   import game_pkg::*;
#(
   parameter int NUM_LIVES    = 3,
   parameter int NUM_LEVELS   = 4,
   parameter int DEATH_FRAMES = 120,
   parameter int CLEAR_FRAMES = 180
) (
   input  logic            Clk,
   input  logic            RESET_N,
   game_phase_ctrl_if.slave bus
);

   localparam int TW = timer_width(DEATH_FRAMES, CLEAR_FRAMES);
   localparam logic [TW-1:0] DEATH_LOAD = TW'(DEATH_FRAMES - 1);
   localparam logic [TW-1:0] CLEAR_LOAD = TW'(CLEAR_FRAMES - 1);
   localparam logic [3:0]    LIVES_INIT = 4'(NUM_LIVES);
   localparam logic [3:0]    LAST_LEVEL = 4'(NUM_LEVELS - 1);

   phase_e          state;
   phase_e          next_state;
   logic            start_hist;
   logic            pause_hist;
   logic            start_edge;
   logic            pause_edge;
   logic [3:0]      lives_cnt;
   logic [3:0]      lives_next;
   logic [3:0]      level_cnt;
   logic [3:0]      level_next;
   logic            load_pulse;
   logic            load_next;
   logic            respawn_pulse;
   logic            respawn_next;
   logic            timer_load;
   logic [TW-1:0]   timer_value;
   logic            timer_expired;
   logic [PHASE_W-1:0] phase_dec;

   assign start_edge = bus.start & ~start_hist;
   assign pause_edge = bus.pause & ~pause_hist;

   frame_countdown #(.WIDTH(TW)) timer (
      .clk        (Clk),
      .rst_n      (RESET_N),
      .load       (timer_load),
      .load_value (timer_value),
      .tick       (bus.frame_tick),
      .expired    (timer_expired)
   );

   // State register plus key history, counters and the one-cycle pulses;
   // key history resets high so a key held through reset does not count.
   always_ff @(posedge Clk or negedge RESET_N) begin
      if (!RESET_N) begin
         state         <= PH_TITLE;
         start_hist    <= 1'b1;
         pause_hist    <= 1'b1;
         lives_cnt     <= '0;
         level_cnt     <= '0;
         load_pulse    <= 1'b0;
         respawn_pulse <= 1'b0;
      end else begin
         state         <= next_state;
         start_hist    <= bus.start;
         pause_hist    <= bus.pause;
         lives_cnt     <= lives_next;
         level_cnt     <= level_next;
         load_pulse    <= load_next;
         respawn_pulse <= respawn_next;
      end
   end

   // Next-state logic; death beats level end, which beats a pause edge.
   always_comb begin
      next_state   = state;
      lives_next   = lives_cnt;
      level_next   = level_cnt;
      load_next    = 1'b0;
      respawn_next = 1'b0;
      timer_load   = 1'b0;
      timer_value  = '0;
      case (state)
         PH_TITLE: begin
            if (start_edge) begin
               next_state = PH_PLAYING;
               lives_next = LIVES_INIT;
               level_next = '0;
               load_next  = 1'b1;
            end
         end
         PH_PLAYING: begin
            if (!bus.mario_alive) begin
               next_state  = PH_DYING;
               lives_next  = (lives_cnt == '0) ? '0 : lives_cnt - 4'd1;
               timer_load  = 1'b1;
               timer_value = DEATH_LOAD;
            end else if (bus.level_end) begin
               next_state  = PH_CLEAR;
               timer_load  = 1'b1;
               timer_value = CLEAR_LOAD;
            end else if (pause_edge) begin
               next_state = PH_PAUSED;
            end
         end
         PH_PAUSED: begin
            if (pause_edge) begin
               next_state = PH_PLAYING;
            end
         end
         PH_DYING: begin
            if (timer_expired) begin
               if (lives_cnt == '0) begin
                  next_state = PH_GAME_OVER;
               end else begin
                  next_state   = PH_PLAYING;
                  respawn_next = 1'b1;
               end
            end
         end
         PH_CLEAR: begin
            if (timer_expired) begin
               if (level_cnt == LAST_LEVEL) begin
                  next_state = PH_WIN;
               end else begin
                  next_state = PH_PLAYING;
                  level_next = level_cnt + 4'd1;
                  load_next  = 1'b1;
               end
            end
         end
         PH_GAME_OVER, PH_WIN: begin
            if (start_edge) begin
               next_state = PH_TITLE;
            end
         end
         default: next_state = PH_TITLE;
      endcase
   end

   // One-hot screen select decoded from the registered state.
   always_comb begin
      phase_dec = '0;
      case (state)
         PH_TITLE:     phase_dec[IDX_TITLE]     = 1'b1;
         PH_PLAYING:   phase_dec[IDX_PLAYING]   = 1'b1;
         PH_PAUSED:    phase_dec[IDX_PAUSED]    = 1'b1;
         PH_DYING:     phase_dec[IDX_DYING]     = 1'b1;
         PH_CLEAR:     phase_dec[IDX_CLEAR]     = 1'b1;
         PH_GAME_OVER: phase_dec[IDX_GAME_OVER] = 1'b1;
         PH_WIN:       phase_dec[IDX_WIN]       = 1'b1;
         default:      phase_dec[IDX_TITLE]     = 1'b1;
      endcase
   end

   assign bus.phase      = phase_dec;
   assign bus.lives_left = lives_cnt;
   assign bus.level      = level_cnt;
   assign bus.load_level = load_pulse;
   assign bus.respawn    = respawn_pulse;

endmodule

// File: tb/tb_game_phase_ctrl.sv
// Directed bench for game_phase_ctrl: start, death/respawn, pause priority,
// game over, level clear and win, and asynchronous reset mid-clear.
module tb_game_phase_ctrl;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   game_phase_ctrl_if bus ();

   game_phase_ctrl #(
      .NUM_LIVES    (3),
      .NUM_LEVELS   (2),
      .DEATH_FRAMES (120),
      .CLEAR_FRAMES (180)
   ) dut (
      .Clk     (clk),
      .RESET_N (rst_n),
      .bus     (bus)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance n clock edges and settle just after the last one.
   task automatic run_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One counted comparison against a hand-computed value.
   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Directed sequence.
   initial begin
      total           = 0;
      bad             = 0;
      rst_n           = 1'b0;
      bus.frame_tick  = 1'b0;
      bus.start       = 1'b0;
      bus.pause       = 1'b0;
      bus.mario_alive = 1'b1;
      bus.level_end   = 1'b0;

      run_cycles(2);
      check_output("rst_phase", 32'(bus.phase), 'b1000000);
      check_output("rst_lives", 32'(bus.lives_left), 0);
      check_output("rst_level", 32'(bus.level), 0);
      check_output("rst_load", 32'(bus.load_level), 0);
      check_output("rst_respawn", 32'(bus.respawn), 0);
      rst_n = 1'b1;
      run_cycles(1);
      check_output("idle_title", 32'(bus.phase), 'b1000000);

      $display("[TB] start a game");
      bus.start = 1'b1;
      run_cycles(1);
      check_output("start_phase", 32'(bus.phase), 'b0100000);
      check_output("start_lives", 32'(bus.lives_left), 3);
      check_output("start_level", 32'(bus.level), 0);
      check_output("start_load", 32'(bus.load_level), 1);
      for (int i = 0; i < 10; i++) begin
         run_cycles(1);
         check_output("hold_load", 32'(bus.load_level), 0);
      end
      check_output("hold_phase", 32'(bus.phase), 'b0100000);
      check_output("hold_lives", 32'(bus.lives_left), 3);
      bus.start = 1'b0;

      $display("[TB] death and respawn");
      bus.mario_alive = 1'b0;
      run_cycles(1);
      check_output("die_phase", 32'(bus.phase), 'b0001000);
      check_output("die_lives", 32'(bus.lives_left), 2);
      bus.mario_alive = 1'b1;
      bus.frame_tick  = 1'b1;
      run_cycles(119);
      check_output("die_119", 32'(bus.phase), 'b0001000);
      run_cycles(1);
      check_output("die_120", 32'(bus.phase), 'b0100000);
      check_output("respawn_hi", 32'(bus.respawn), 1);
      check_output("respawn_noload", 32'(bus.load_level), 0);
      bus.frame_tick = 1'b0;
      run_cycles(1);
      check_output("respawn_lo", 32'(bus.respawn), 0);

      $display("[TB] pause and priority");
      bus.pause = 1'b1;
      run_cycles(1);
      check_output("pause_phase", 32'(bus.phase), 'b0010000);
      bus.mario_alive = 1'b0;
      run_cycles(3);
      check_output("paused_dead_phase", 32'(bus.phase), 'b0010000);
      check_output("paused_dead_lives", 32'(bus.lives_left), 2);
      bus.pause = 1'b0;
      run_cycles(1);
      bus.pause = 1'b1;
      run_cycles(1);
      check_output("unpause_phase", 32'(bus.phase), 'b0100000);
      run_cycles(1);
      check_output("unpause_die", 32'(bus.phase), 'b0001000);
      check_output("unpause_lives", 32'(bus.lives_left), 1);
      bus.pause       = 1'b0;
      bus.mario_alive = 1'b1;
      bus.frame_tick  = 1'b1;
      run_cycles(120);
      check_output("respawn2_phase", 32'(bus.phase), 'b0100000);
      check_output("respawn2_hi", 32'(bus.respawn), 1);
      bus.frame_tick = 1'b0;

      $display("[TB] simultaneous death, level end and pause");
      bus.mario_alive = 1'b0;
      bus.level_end   = 1'b1;
      bus.pause       = 1'b1;
      run_cycles(1);
      check_output("simul_phase", 32'(bus.phase), 'b0001000);
      check_output("simul_lives", 32'(bus.lives_left), 0);
      bus.mario_alive = 1'b1;
      bus.level_end   = 1'b0;
      bus.pause       = 1'b0;
      bus.frame_tick  = 1'b1;
      run_cycles(120);
      check_output("gameover_phase", 32'(bus.phase), 'b0000010);
      check_output("gameover_respawn", 32'(bus.respawn), 0);
      check_output("gameover_lives", 32'(bus.lives_left), 0);
      bus.frame_tick = 1'b0;
      bus.start      = 1'b1;
      run_cycles(1);
      check_output("gameover_title", 32'(bus.phase), 'b1000000);
      bus.start = 1'b0;
      run_cycles(1);

      $display("[TB] level clear and win");
      bus.start = 1'b1;
      run_cycles(1);
      check_output("game2_phase", 32'(bus.phase), 'b0100000);
      check_output("game2_lives", 32'(bus.lives_left), 3);
      bus.start = 1'b0;
      run_cycles(1);
      bus.start = 1'b1;
      run_cycles(1);
      check_output("start_ignored", 32'(bus.phase), 'b0100000);
      check_output("start_ignored_load", 32'(bus.load_level), 0);
      bus.start     = 1'b0;
      bus.level_end = 1'b1;
      run_cycles(1);
      check_output("clear_phase", 32'(bus.phase), 'b0000100);
      bus.level_end  = 1'b0;
      bus.frame_tick = 1'b1;
      run_cycles(179);
      check_output("clear_179", 32'(bus.phase), 'b0000100);
      run_cycles(1);
      check_output("clear_180", 32'(bus.phase), 'b0100000);
      check_output("clear_level", 32'(bus.level), 1);
      check_output("clear_load_hi", 32'(bus.load_level), 1);
      bus.frame_tick = 1'b0;
      run_cycles(1);
      check_output("clear_load_lo", 32'(bus.load_level), 0);
      bus.level_end = 1'b1;
      run_cycles(1);
      bus.level_end  = 1'b0;
      bus.frame_tick = 1'b1;
      run_cycles(180);
      check_output("win_phase", 32'(bus.phase), 'b0000001);
      check_output("win_level", 32'(bus.level), 1);
      check_output("win_load", 32'(bus.load_level), 0);
      bus.frame_tick = 1'b0;
      bus.start      = 1'b1;
      run_cycles(1);
      check_output("win_title", 32'(bus.phase), 'b1000000);
      check_output("win_hold_level", 32'(bus.level), 1);

      $display("[TB] reset in the middle of a clear");
      bus.start = 1'b0;
      run_cycles(1);
      bus.start = 1'b1;
      run_cycles(1);
      check_output("game3_level", 32'(bus.level), 0);
      bus.start     = 1'b0;
      bus.level_end = 1'b1;
      run_cycles(1);
      bus.level_end  = 1'b0;
      bus.frame_tick = 1'b1;
      run_cycles(50);
      check_output("midclear_phase", 32'(bus.phase), 'b0000100);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("async_phase", 32'(bus.phase), 'b1000000);
      check_output("async_lives", 32'(bus.lives_left), 0);
      check_output("async_level", 32'(bus.level), 0);
      check_output("async_load", 32'(bus.load_level), 0);
      check_output("async_respawn", 32'(bus.respawn), 0);
      bus.frame_tick = 1'b0;
      #3;
      rst_n = 1'b1;
      run_cycles(1);
      check_output("post_rst_phase", 32'(bus.phase), 'b1000000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
